// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 5209;
  localparam int unsigned FRAME_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous idle-high line; resets to 1.
module uart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, stop-bit check, valid/ack handshake with sticky flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic               sclk,
  input  logic               reset,
  input  logic               din,
  output logic [FRAME_W-1:0] data,
  output logic               rx_valid,
  input  logic               rx_ack,
  output logic               frame_err,
  output logic               overrun,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic din_s;

  rx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic               busy_q, busy_d;
  logic               deliver_c, ferr_set_c;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (sclk),
    .rst_ni (reset),
    .d_i    (din),
    .q_o    (din_s)
  );

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    deliver_c   = 1'b0;
    ferr_set_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!din_s) begin
          state_d = ST_START;
          cnt_d   = CNT_HALF;
        end
      end
      ST_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!din_s) begin
          state_d = ST_DATA;
          cnt_d   = CNT_FULL;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shift_d[idx_q] = din_s;
          cnt_d          = CNT_FULL;
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (din_s) begin
          state_d   = ST_IDLE;
          deliver_c = 1'b1;
        end else begin
          state_d    = ST_BREAK;
          ferr_set_c = 1'b1;
        end
      end
      ST_BREAK: begin
        if (din_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Ack clears first; a same-cycle delivery or framing error then takes priority.
    if (rx_ack) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      rx_valid_d  = 1'b0;
    end
    if (deliver_c) begin
      data_d     = shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
    end
    if (ferr_set_c) frame_err_d = 1'b1;

    busy_d = (state_d != ST_IDLE);
  end

  assign data      = data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic       sclk = 1'b0;
  logic       reset;
  logic       din;
  logic [7:0] data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .sclk      (sclk),
    .reset     (reset),
    .din       (din),
    .data      (data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic [7:0] d;
    bit         stop;
    bit         ack;
    logic [7:0] e_data;
    bit         e_valid;
    bit         e_ferr;
    bit         e_ovr;
    bit         e_busy;
  } vec_t;

  vec_t vecs[8];

  // Reference state for the randomized section.
  logic [7:0] m_data;
  bit         m_valid, m_ferr, m_ovr;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] ed, input bit ev,
                           input bit ef, input bit eo, input bit eb);
    check({name, ".data"},      data,             ed);
    check({name, ".rx_valid"},  {7'd0, rx_valid}, {7'd0, ev});
    check({name, ".frame_err"}, {7'd0, frame_err},{7'd0, ef});
    check({name, ".overrun"},   {7'd0, overrun},  {7'd0, eo});
    check({name, ".busy"},      {7'd0, busy},     {7'd0, eb});
  endtask

  task automatic idle(input int n);
    din = 1'b1;
    repeat (n) @(negedge sclk);
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge sclk);
    rx_ack = 1'b0;
  endtask

  // Drives one full 10-bit frame starting at a negedge; rx_ack pulses at clock ack_at of the frame.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int ack_at);
    for (int k = 0; k < 10 * CPB; k++) begin
      int slot;
      slot = k / CPB;
      if (slot == 0)      din = 1'b0;
      else if (slot <= 8) din = b[slot-1];
      else                din = stop;
      rx_ack = (k == ack_at);
      @(negedge sclk);
    end
    rx_ack = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h02, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h3C, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};

    reset  = 1'b0;
    din    = 1'b1;
    rx_ack = 1'b0;
    repeat (3) @(negedge sclk);
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    idle(4);

    // Frames back to back with zero idle gap except after a framing error.
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].d, vecs[i].stop, vecs[i].ack ? 2 : -1);
      check_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_valid,
                vecs[i].e_ferr, vecs[i].e_ovr, vecs[i].e_busy);
      if (!vecs[i].stop) begin
        din = 1'b0;
        repeat (40) @(negedge sclk);
        check("break_busy", {7'd0, busy}, 8'd1);
        check("break_ferr", {7'd0, frame_err}, 8'd1);
        idle(20);
        check("break_exit_busy", {7'd0, busy}, 8'd0);
      end
    end

    pulse_ack();
    check("ack_clears_valid", {7'd0, rx_valid}, 8'd0);

    // Short low glitch must be rejected at the start-bit mid sample.
    din = 1'b0;
    repeat (5) @(negedge sclk);
    din = 1'b1;
    repeat (3) @(negedge sclk);
    check("glitch_busy", {7'd0, busy}, 8'd1);
    idle(20);
    check_all("glitch", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

    // Ack landing exactly in the delivery cycle with a byte still pending.
    send_frame(8'h44, 1'b1, -1);
    check("pend_valid", {7'd0, rx_valid}, 8'd1);
    send_frame(8'h55, 1'b1, 9 * CPB + 10);
    check_all("same_cycle_ack", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset during bit 4 of 0xFF, then a clean frame.
    din = 1'b0;
    repeat (CPB) @(negedge sclk);
    din = 1'b1;
    repeat (4 * CPB + 8) @(negedge sclk);
    check("midframe_busy", {7'd0, busy}, 8'd1);
    reset = 1'b0;
    #1;
    check_all("midframe_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge sclk);
    reset = 1'b1;
    idle(4 * CPB);
    send_frame(8'h80, 1'b1, -1);
    check_all("after_reset", 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized frames against a frame-level model.
    m_data  = 8'h80;
    m_valid = 1'b1;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      bit stop, ack;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      ack  = ($urandom_range(0, 1) != 0);
      send_frame(b, stop, ack ? 2 : -1);
      if (ack) begin
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
      end
      if (stop) begin
        if (m_valid) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_data  = b;
      end else begin
        m_ferr = 1'b1;
      end
      check_all($sformatf("rand%0d", i), m_data, m_valid, m_ferr, m_ovr, !stop);
      if (!stop) begin
        idle(24);
        check("rand_break_exit", {7'd0, busy}, 8'd0);
      end
    end

    pulse_ack();
    check_all("final_ack", m_data, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
